// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: ROM strobe/address generation, tagged FIFO, valid/ready to core.
// Optional PREFETCH_PERF_EN adds perf_discard_cnt, the number of words thrown away by redirects.
module instr_prefetch_buffer #(
  parameter int          ADDR_WIDTH = 15,
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  rom_stb,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  rom_ack,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [31:0]           if_pc,
  output logic [DATA_WIDTH-1:0] if_instr
`ifdef PREFETCH_PERF_EN
  ,
  output logic [15:0]           perf_discard_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]           fetch_pc;
  logic [31:0]           inflight_pc;
  logic                  inflight;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [31:0]           mem_pc   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [CW:0]           occupancy;
  logic                  push;
  logic                  pop;
  logic                  unused_redirect_lsbs;

  // Credits: buffered words plus the one outstanding read may never exceed the FIFO size.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight);
  assign rom_stb   = rst_n && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign rom_addr  = fetch_pc[ADDR_WIDTH-1:0];

  assign push = rom_ack && inflight && !redirect_valid;
  assign pop  = if_valid && if_ready && !redirect_valid;

  assign if_valid = (count != '0);
  assign if_pc    = if_valid ? mem_pc[rd_ptr]   : '0;
  assign if_instr = if_valid ? mem_data[rd_ptr] : '0;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // NOTE: storage has no reset; outputs are masked by if_valid, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= inflight_pc;
      mem_data[wr_ptr] <= rom_data;
    end
  end

  // NOTE: non-blocking assignments throughout, so every term reads the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= rom_stb;
      if (rom_stb) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef PREFETCH_PERF_EN
  logic [16:0] perf_sum;

  // Discarded words = buffered entries plus a read landing in the redirect cycle.
  assign perf_sum = {1'b0, perf_discard_cnt} + 17'(count) + 17'(rom_ack && inflight);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_discard_cnt <= '0;
    end else if (redirect_valid) begin
      perf_discard_cnt <= perf_sum[16] ? 16'hFFFF : perf_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Self-checking bench for instr_prefetch_buffer: directed timing scenarios plus a randomized
// run against an in-order PC-stream reference model with a behavioural 1-cycle ROM.
module tb_instr_prefetch_buffer;
  localparam int AW    = 15;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rom_stb;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic          rom_ack = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          if_valid;
  logic          if_ready = 1'b0;
  logic [31:0]   if_pc;
  logic [DW-1:0] if_instr;
`ifdef PREFETCH_PERF_EN
  logic [15:0]   perf_discard_cnt;
`endif

  int total = 0;
  int bad   = 0;

  instr_prefetch_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_stb        (rom_stb),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_ack        (rom_ack),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
`ifdef PREFETCH_PERF_EN
    ,
    .perf_discard_cnt (perf_discard_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ROM contents: word i holds 0x1000_0000 + i, aliased over the ROM address space.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h1000_0000 + 32'(addr[AW-1:2]);
  endfunction

  // One clock: sample the strobe, advance past the edge, answer with the ROM read.
  task automatic step();
    logic          s;
    logic [AW-1:0] a;
    s = rom_stb;
    a = rom_addr;
    @(posedge clk);
    #1;
    rom_ack  = s;
    rom_data = rom_word(32'(a));
  endtask

  // Leaves the bench one time unit after an edge with rst_n just released (cycle 0).
  task automatic apply_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    #1;
    total++; if (rom_stb !== 1'b0) begin bad++; $display("FAIL reset_stb got=%b want=0", rom_stb); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", if_valid); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", if_pc); end
    total++; if (if_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", if_instr); end
    total++; if (rom_addr !== 15'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", rom_addr); end
`ifdef PREFETCH_PERF_EN
    total++; if (perf_discard_cnt !== 16'h0) begin bad++; $display("FAIL reset_perf got=%0d want=0", perf_discard_cnt); end
`endif
  endtask

  task automatic test_stream();
    apply_reset();
    if_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c == 0) begin
        total++; if (rom_stb !== 1'b1) begin bad++; $display("FAIL stream_stb0 got=%b want=1", rom_stb); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL stream_valid0 got=%b want=0", if_valid); end
      end else if (c == 1) begin
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL stream_valid1 got=%b want=0", if_valid); end
      end else begin
        total++; if (if_valid !== 1'b1) begin bad++; $display("FAIL stream_valid c=%0d got=%b want=1", c, if_valid); end
        total++; if (if_pc !== 32'(4 * (c - 2))) begin bad++; $display("FAIL stream_pc c=%0d got=%h want=%h", c, if_pc, 32'(4 * (c - 2))); end
        total++; if (if_instr !== 32'h1000_0000 + 32'(c - 2)) begin bad++; $display("FAIL stream_instr c=%0d got=%h want=%h", c, if_instr, 32'h1000_0000 + 32'(c - 2)); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int issues;
    issues = 0;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rom_stb) issues++;
      step();
    end
    #1;
    total++; if (issues != DEPTH) begin bad++; $display("FAIL bp_issues got=%0d want=%0d", issues, DEPTH); end
    total++; if (rom_stb !== 1'b0) begin bad++; $display("FAIL bp_stb_held got=%b want=0", rom_stb); end
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin bad++; $display("FAIL bp_head got=%b/%h want=1/0", if_valid, if_pc); end
    if_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) || if_instr !== 32'h1000_0000 + 32'(k)) begin
        bad++;
        $display("FAIL bp_drain k=%0d got=%b/%h/%h want=1/%h/%h", k, if_valid, if_pc, if_instr, 32'(4 * k), 32'h1000_0000 + 32'(k));
      end
      step();
    end
  endtask

  task automatic test_redirect_flush();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      #1;
      step();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    total++; if (if_valid !== 1'b1 || rom_ack !== 1'b1) begin bad++; $display("FAIL flush_pre got=%b/%b want=1/1", if_valid, rom_ack); end
    total++; if (rom_stb !== 1'b0) begin bad++; $display("FAIL flush_stb got=%b want=0", rom_stb); end
    step();
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    #1;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL flush_valid1 got=%b want=0", if_valid); end
    total++; if (rom_addr !== 15'h0100 || rom_stb !== 1'b1) begin bad++; $display("FAIL flush_addr got=%h/%b want=0100/1", rom_addr, rom_stb); end
`ifdef PREFETCH_PERF_EN
    total++; if (perf_discard_cnt !== 16'd4) begin bad++; $display("FAIL flush_perf got=%0d want=4", perf_discard_cnt); end
`endif
    step();
    #1;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL flush_valid2 got=%b want=0", if_valid); end
    step();
    #1;
    total++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0000_0100 || if_instr !== rom_word(32'h100)) begin
      bad++;
      $display("FAIL flush_first got=%b/%h/%h want=1/00000100/%h", if_valid, if_pc, if_instr, rom_word(32'h100));
    end
    step();
  endtask

  task automatic test_back_to_back();
    int first;
    bit leak;
    first = -1;
    leak  = 1'b0;
    apply_reset();
    if_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      step();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    #1;
    step();
    redirect_pc = 32'h0000_0080;
    #1;
    step();
    redirect_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      #1;
      if (if_valid && first < 0) begin
        first = k;
        total++; if (if_pc !== 32'h80) begin bad++; $display("FAIL b2b_first_pc got=%h want=00000080", if_pc); end
      end
      if (if_valid && if_pc >= 32'h40 && if_pc < 32'h80) leak = 1'b1;
      step();
    end
    total++; if (first != 3) begin bad++; $display("FAIL b2b_latency got=%0d want=3", first); end
    total++; if (leak) begin bad++; $display("FAIL b2b_leak got=1 want=0"); end
  endtask

  task automatic test_spurious_ack();
    apply_reset();
    if_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      step();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    #1;
    step();
    redirect_valid = 1'b0;
    rom_ack  = 1'b1;
    rom_data = 32'hDEAD_BEEF;
    #1;
    step();
    #1;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL spur_valid got=%b want=0", if_valid); end
    step();
    #1;
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin bad++; $display("FAIL spur_first got=%b/%h want=1/00000200", if_valid, if_pc); end
    step();
    #1;
    total++; if (if_pc !== 32'h204 || if_instr !== rom_word(32'h204)) begin bad++; $display("FAIL spur_next got=%h/%h want=00000204/%h", if_pc, if_instr, rom_word(32'h204)); end
    step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      #1;
      step();
    end
    #1;
    total++; if (if_valid !== 1'b1 || rom_ack !== 1'b1) begin bad++; $display("FAIL rmid_pre got=%b/%b want=1/1", if_valid, rom_ack); end
    rst_n = 1'b0;
    #1;
    total++;
    if (rom_stb !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || rom_addr !== 15'h0) begin
      bad++;
      $display("FAIL rmid_outputs got=%b/%b/%h/%h/%h want=0/0/0/0/0", rom_stb, if_valid, if_pc, if_instr, rom_addr);
    end
    step();
    step();
    rst_n    = 1'b1;
    if_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (c < 2) begin
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rmid_early c=%0d got=%b want=0", c, if_valid); end
      end else begin
        total++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== rom_word(32'h0)) begin bad++; $display("FAIL rmid_first got=%b/%h/%h want=1/0/%h", if_valid, if_pc, if_instr, rom_word(32'h0)); end
      end
      step();
    end
  endtask

  // Reference: the core sees an unbroken +4 PC stream from each restart point; reads follow the
  // same stream; outstanding reads (issued minus delivered since last restart) stay within DEPTH.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    int          outstanding;
    int          accepts;
    bit          prev_redirect;
    exp_pc        = 32'h0;
    exp_fetch     = 32'h0;
    outstanding   = 0;
    accepts       = 0;
    prev_redirect = 1'b0;
    apply_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      #1;
      if (prev_redirect) begin
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rnd_post_redirect cyc=%0d got=%b want=0", cyc, if_valid); end
      end
      if (redirect_valid) begin
        total++; if (rom_stb !== 1'b0) begin bad++; $display("FAIL rnd_redirect_stb cyc=%0d got=%b want=0", cyc, rom_stb); end
      end
      if (rom_stb) begin
        total++; if (rom_addr !== exp_fetch[AW-1:0]) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", cyc, rom_addr, exp_fetch[AW-1:0]); end
        exp_fetch += 32'd4;
        outstanding++;
      end
      if (if_valid && !redirect_valid) begin
        total++;
        if (if_pc !== exp_pc || if_instr !== rom_word(exp_pc)) begin
          bad++;
          $display("FAIL rnd_head cyc=%0d got=%h/%h want=%h/%h", cyc, if_pc, if_instr, exp_pc, rom_word(exp_pc));
        end
        if (if_ready) begin
          exp_pc += 32'd4;
          outstanding--;
          accepts++;
        end
      end
      if (redirect_valid) begin
        exp_pc      = {redirect_pc[31:2], 2'b00};
        exp_fetch   = {redirect_pc[31:2], 2'b00};
        outstanding = 0;
      end
      total++;
      if (outstanding < 0 || outstanding > DEPTH) begin
        bad++;
        $display("FAIL rnd_credit cyc=%0d got=%0d want=0..%0d", cyc, outstanding, DEPTH);
      end
      prev_redirect = redirect_valid;
      step();
    end
    redirect_valid = 1'b0;
    total++; if (accepts < 100) begin bad++; $display("FAIL rnd_throughput got=%0d want>=100", accepts); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_back_to_back();
    test_spurious_ack();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
